// File: rtl/storage_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : storage_cmd_master
// Description : Host-command initiator for the buffer/LIFO/FIFO storage top.
//               Turns each accepted host command into a one-cycle storage
//               transaction, guards LIFO/FIFO accesses against full/empty,
//               captures read data after RD_LAT cycles and returns exactly
//               one response per command. Keeps saturating counts of
//               completed writes, reads and rejected commands.
// Revision    : 1.0 - initial release
// ============================================================================
module storage_cmd_master #(
    parameter int DinLENGTH = 32,
    parameter int WIDTH     = 4,
    parameter int RD_LAT    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    // host request channel
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_target,
    input  logic                 cmd_write,
    input  logic [WIDTH-1:0]     cmd_addr,
    input  logic [DinLENGTH-1:0] cmd_data,
    // host response channel
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DinLENGTH-1:0] rsp_data,
    output logic                 rsp_err,
    // storage interface
    output logic                 chip_en_buf,
    output logic                 chip_en_lifo,
    output logic                 chip_en_fifo,
    output logic [DinLENGTH-1:0] din,
    output logic [WIDTH-1:0]     addr,
    output logic                 r_w,
    output logic                 valid,
    output logic [1:0]           opcode,
    input  logic [DinLENGTH-1:0] dout,
    input  logic                 full,
    input  logic                 empty,
    // statistics
    output logic [15:0]          wr_cnt,
    output logic [15:0]          rd_cnt,
    output logic [15:0]          err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT_RD = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    localparam logic [1:0]  C_TGT_BUF  = 2'b00;
    localparam logic [1:0]  C_TGT_LIFO = 2'b01;
    localparam logic [1:0]  C_TGT_FIFO = 2'b10;
    localparam logic [1:0]  C_TGT_RSVD = 2'b11;
    localparam logic [1:0]  C_OP_IDLE  = 2'b00;
    localparam logic [1:0]  C_OP_WR    = 2'b01;
    localparam logic [1:0]  C_OP_RD    = 2'b10;
    localparam logic [2:0]  C_RD_LOAD  = 3'(RD_LAT - 1);
    localparam logic [15:0] C_CNT_MAX  = 16'hFFFF;

    state_t                 r_state_q,    w_state_d;
    logic [2:0]             r_lat_q,      w_lat_d;
    logic                   r_valid_q,    w_valid_d;
    logic                   r_ce_buf_q,   w_ce_buf_d;
    logic                   r_ce_lifo_q,  w_ce_lifo_d;
    logic                   r_ce_fifo_q,  w_ce_fifo_d;
    logic                   r_r_w_q,      w_r_w_d;
    logic [1:0]             r_opcode_q,   w_opcode_d;
    logic [DinLENGTH-1:0]   r_din_q,      w_din_d;
    logic [WIDTH-1:0]       r_addr_q,     w_addr_d;
    logic [DinLENGTH-1:0]   r_rsp_data_q, w_rsp_data_d;
    logic                   r_rsp_err_q,  w_rsp_err_d;
    logic                   r_is_wr_q,    w_is_wr_d;
    logic [15:0]            r_wr_cnt_q,   w_wr_cnt_d;
    logic [15:0]            r_rd_cnt_q,   w_rd_cnt_d;
    logic [15:0]            r_err_cnt_q,  w_err_cnt_d;

    logic w_accept;
    logic w_queue_tgt;
    logic w_cmd_err;

    // Ready is withheld while reset is asserted so nothing is accepted then.
    assign cmd_ready   = (r_state_q == S_IDLE) && !reset;
    assign w_accept    = cmd_valid && cmd_ready;
    assign w_queue_tgt = (cmd_target == C_TGT_LIFO) || (cmd_target == C_TGT_FIFO);
    // Only LIFO/FIFO can overflow/underflow; the reserved target is always rejected.
    assign w_cmd_err   = (cmd_target == C_TGT_RSVD) ||
                         (w_queue_tgt && (cmd_write ? full : empty));

    // Next-state, downstream transaction and response/counter updates.
    always_comb begin
        w_state_d    = r_state_q;
        w_lat_d      = r_lat_q;
        w_valid_d    = r_valid_q;
        w_ce_buf_d   = r_ce_buf_q;
        w_ce_lifo_d  = r_ce_lifo_q;
        w_ce_fifo_d  = r_ce_fifo_q;
        w_r_w_d      = r_r_w_q;
        w_opcode_d   = r_opcode_q;
        w_din_d      = r_din_q;
        w_addr_d     = r_addr_q;
        w_rsp_data_d = r_rsp_data_q;
        w_rsp_err_d  = r_rsp_err_q;
        w_is_wr_d    = r_is_wr_q;
        w_wr_cnt_d   = r_wr_cnt_q;
        w_rd_cnt_d   = r_rd_cnt_q;
        w_err_cnt_d  = r_err_cnt_q;

        case (r_state_q)
            S_IDLE: begin
                if (w_accept) begin
                    w_is_wr_d    = cmd_write;
                    w_rsp_data_d = '0;
                    if (w_cmd_err) begin
                        // Rejected: answer directly, storage is never touched.
                        w_rsp_err_d = 1'b1;
                        w_state_d   = S_RESP;
                    end else begin
                        w_rsp_err_d = 1'b0;
                        w_valid_d   = 1'b1;
                        w_ce_buf_d  = (cmd_target == C_TGT_BUF);
                        w_ce_lifo_d = (cmd_target == C_TGT_LIFO);
                        w_ce_fifo_d = (cmd_target == C_TGT_FIFO);
                        w_r_w_d     = cmd_write;
                        w_opcode_d  = cmd_write ? C_OP_WR : C_OP_RD;
                        w_din_d     = cmd_write ? cmd_data : '0;
                        w_addr_d    = (cmd_target == C_TGT_BUF) ? cmd_addr : '0;
                        w_state_d   = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // The strobe lives for exactly this one cycle; din/addr/r_w hold.
                w_valid_d   = 1'b0;
                w_ce_buf_d  = 1'b0;
                w_ce_lifo_d = 1'b0;
                w_ce_fifo_d = 1'b0;
                w_opcode_d  = C_OP_IDLE;
                w_lat_d     = C_RD_LOAD;
                w_state_d   = r_is_wr_q ? S_RESP : S_WAIT_RD;
            end
            S_WAIT_RD: begin
                if (r_lat_q == 3'd0) begin
                    w_rsp_data_d = dout;
                    w_rsp_err_d  = 1'b0;
                    w_state_d    = S_RESP;
                end else begin
                    w_lat_d = r_lat_q - 3'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_d = S_IDLE;
                    if (r_rsp_err_q) begin
                        if (r_err_cnt_q != C_CNT_MAX) w_err_cnt_d = r_err_cnt_q + 16'd1;
                    end else if (r_is_wr_q) begin
                        if (r_wr_cnt_q != C_CNT_MAX) w_wr_cnt_d = r_wr_cnt_q + 16'd1;
                    end else begin
                        if (r_rd_cnt_q != C_CNT_MAX) w_rd_cnt_d = r_rd_cnt_q + 16'd1;
                    end
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset drops any in-flight command.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q    <= S_IDLE;
            r_lat_q      <= 3'd0;
            r_valid_q    <= 1'b0;
            r_ce_buf_q   <= 1'b0;
            r_ce_lifo_q  <= 1'b0;
            r_ce_fifo_q  <= 1'b0;
            r_r_w_q      <= 1'b0;
            r_opcode_q   <= C_OP_IDLE;
            r_din_q      <= '0;
            r_addr_q     <= '0;
            r_rsp_data_q <= '0;
            r_rsp_err_q  <= 1'b0;
            r_is_wr_q    <= 1'b0;
            r_wr_cnt_q   <= 16'd0;
            r_rd_cnt_q   <= 16'd0;
            r_err_cnt_q  <= 16'd0;
        end else begin
            r_state_q    <= w_state_d;
            r_lat_q      <= w_lat_d;
            r_valid_q    <= w_valid_d;
            r_ce_buf_q   <= w_ce_buf_d;
            r_ce_lifo_q  <= w_ce_lifo_d;
            r_ce_fifo_q  <= w_ce_fifo_d;
            r_r_w_q      <= w_r_w_d;
            r_opcode_q   <= w_opcode_d;
            r_din_q      <= w_din_d;
            r_addr_q     <= w_addr_d;
            r_rsp_data_q <= w_rsp_data_d;
            r_rsp_err_q  <= w_rsp_err_d;
            r_is_wr_q    <= w_is_wr_d;
            r_wr_cnt_q   <= w_wr_cnt_d;
            r_rd_cnt_q   <= w_rd_cnt_d;
            r_err_cnt_q  <= w_err_cnt_d;
        end
    end

    assign rsp_valid    = (r_state_q == S_RESP);
    assign rsp_data     = r_rsp_data_q;
    assign rsp_err      = r_rsp_err_q;
    assign valid        = r_valid_q;
    assign chip_en_buf  = r_ce_buf_q;
    assign chip_en_lifo = r_ce_lifo_q;
    assign chip_en_fifo = r_ce_fifo_q;
    assign r_w          = r_r_w_q;
    assign opcode       = r_opcode_q;
    assign din          = r_din_q;
    assign addr         = r_addr_q;
    assign wr_cnt       = r_wr_cnt_q;
    assign rd_cnt       = r_rd_cnt_q;
    assign err_cnt      = r_err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_storage_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_storage_cmd_master
// Description : Directed self-checking bench for storage_cmd_master
//               (RD_LAT = 1). Inputs change and outputs are sampled on the
//               falling edge, midway between active edges.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_storage_cmd_master;

    localparam int DinLENGTH = 32;
    localparam int WIDTH     = 4;
    localparam int RD_LAT    = 1;
    localparam logic [31:0] C_JUNK = 32'hDEADBEEF;

    logic                 clk;
    logic                 reset;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_target;
    logic                 cmd_write;
    logic [WIDTH-1:0]     cmd_addr;
    logic [DinLENGTH-1:0] cmd_data;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [DinLENGTH-1:0] rsp_data;
    logic                 rsp_err;
    logic                 chip_en_buf;
    logic                 chip_en_lifo;
    logic                 chip_en_fifo;
    logic [DinLENGTH-1:0] din;
    logic [WIDTH-1:0]     addr;
    logic                 r_w;
    logic                 valid;
    logic [1:0]           opcode;
    logic [DinLENGTH-1:0] dout;
    logic                 full;
    logic                 empty;
    logic [15:0]          wr_cnt;
    logic [15:0]          rd_cnt;
    logic [15:0]          err_cnt;

    int n_cmp;
    int n_err;

    storage_cmd_master #(
        .DinLENGTH (DinLENGTH),
        .WIDTH     (WIDTH),
        .RD_LAT    (RD_LAT)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_target   (cmd_target),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_data     (cmd_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .chip_en_buf  (chip_en_buf),
        .chip_en_lifo (chip_en_lifo),
        .chip_en_fifo (chip_en_fifo),
        .din          (din),
        .addr         (addr),
        .r_w          (r_w),
        .valid        (valid),
        .opcode       (opcode),
        .dout         (dout),
        .full         (full),
        .empty        (empty),
        .wr_cnt       (wr_cnt),
        .rd_cnt       (rd_cnt),
        .err_cnt      (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", tag, got, exp, $time);
        end
    endtask

    // Present a command on the current falling edge; returns in cycle T+1.
    task automatic send_cmd(input logic [1:0] tgt, input logic wr,
                            input logic [WIDTH-1:0] a, input logic [31:0] d);
        cmd_target = tgt;
        cmd_write  = wr;
        cmd_addr   = a;
        cmd_data   = d;
        cmd_valid  = 1'b1;
        check_eq("cmd_ready_at_accept", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        cmd_valid  = 1'b0;
    endtask

    // Rejected command: no strobe, immediate error response, then err_cnt.
    task automatic err_case(input logic [1:0] tgt, input logic wr, input logic [15:0] exp_cnt);
        send_cmd(tgt, wr, 4'd7, 32'hCAFEF00D);
        check_eq("err_no_valid",   {31'd0, valid}, 32'd0);
        check_eq("err_no_ce",      {29'd0, chip_en_buf, chip_en_lifo, chip_en_fifo}, 32'd0);
        check_eq("err_opcode",     {30'd0, opcode}, 32'd0);
        check_eq("err_rsp_valid",  {31'd0, rsp_valid}, 32'd1);
        check_eq("err_rsp_err",    {31'd0, rsp_err}, 32'd1);
        check_eq("err_rsp_data",   rsp_data, 32'd0);
        @(negedge clk);
        check_eq("err_cnt",        {16'd0, err_cnt}, {16'd0, exp_cnt});
        check_eq("err_rsp_done",   {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_target = 2'b00;
        cmd_write  = 1'b0;
        cmd_addr   = '0;
        cmd_data   = '0;
        rsp_ready  = 1'b1;
        dout       = C_JUNK;
        full       = 1'b0;
        empty      = 1'b0;

        // ---- reset held for two active edges ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rdy_in_reset", {31'd0, cmd_ready}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("rst_strobes",   {26'd0, valid, chip_en_buf, chip_en_lifo, chip_en_fifo,
                                   r_w, rsp_valid}, 32'd0);
        check_eq("rst_opcode",    {30'd0, opcode}, 32'd0);
        check_eq("rst_din",       din, 32'd0);
        check_eq("rst_addr",      {28'd0, addr}, 32'd0);
        check_eq("rst_rsp",       {rsp_data[30:0], rsp_err}, 32'd0);
        check_eq("rst_cnts",      {wr_cnt | rd_cnt | err_cnt, 16'd0}, 32'd0);

        // ---- buffer write ----
        send_cmd(2'b00, 1'b1, 4'd3, 32'h12345678);
        check_eq("bw_valid",  {31'd0, valid}, 32'd1);
        check_eq("bw_ce",     {29'd0, chip_en_buf, chip_en_lifo, chip_en_fifo}, 32'b100);
        check_eq("bw_r_w",    {31'd0, r_w}, 32'd1);
        check_eq("bw_opcode", {30'd0, opcode}, 32'd1);
        check_eq("bw_addr",   {28'd0, addr}, 32'd3);
        check_eq("bw_din",    din, 32'h12345678);
        check_eq("bw_rdy_busy", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        check_eq("bw_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check_eq("bw_rsp_err",   {31'd0, rsp_err}, 32'd0);
        check_eq("bw_valid_off", {31'd0, valid}, 32'd0);
        check_eq("bw_din_hold",  din, 32'h12345678);
        @(negedge clk);
        check_eq("bw_wr_cnt",    {16'd0, wr_cnt}, 32'd1);
        check_eq("bw_idle_rdy",  {31'd0, cmd_ready}, 32'd1);

        // ---- FIFO read, RD_LAT = 1 ----
        send_cmd(2'b10, 1'b0, 4'd9, 32'h11111111);
        check_eq("fr_valid",  {31'd0, valid}, 32'd1);
        check_eq("fr_ce",     {29'd0, chip_en_buf, chip_en_lifo, chip_en_fifo}, 32'b001);
        check_eq("fr_opcode", {30'd0, opcode}, 32'd2);
        check_eq("fr_r_w",    {31'd0, r_w}, 32'd0);
        check_eq("fr_din",    din, 32'd0);
        check_eq("fr_addr",   {28'd0, addr}, 32'd0);
        @(negedge clk);
        check_eq("fr_t2_valid", {31'd0, valid}, 32'd0);
        check_eq("fr_t2_rsp",   {31'd0, rsp_valid}, 32'd0);
        dout = 32'hABBAABBA;
        @(negedge clk);
        dout = C_JUNK;
        check_eq("fr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check_eq("fr_rsp_data",  rsp_data, 32'hABBAABBA);
        check_eq("fr_rsp_err",   {31'd0, rsp_err}, 32'd0);
        @(negedge clk);
        check_eq("fr_rd_cnt",    {16'd0, rd_cnt}, 32'd1);

        // ---- rejected commands ----
        full = 1'b1;
        err_case(2'b01, 1'b1, 16'd1);
        full  = 1'b0;
        empty = 1'b1;
        err_case(2'b10, 1'b0, 16'd2);
        empty = 1'b0;
        err_case(2'b11, 1'b1, 16'd3);
        check_eq("err_wr_cnt_kept", {16'd0, wr_cnt}, 32'd1);

        // ---- buffer reads never see full/empty: full+empty set, still succeeds ----
        full  = 1'b1;
        empty = 1'b1;
        rsp_ready = 1'b0;
        send_cmd(2'b00, 1'b0, 4'd5, 32'h0);
        full  = 1'b0;
        empty = 1'b0;
        check_eq("bp_valid", {31'd0, valid}, 32'd1);
        check_eq("bp_addr",  {28'd0, addr}, 32'd5);
        @(negedge clk);
        dout = 32'h5A5A0001;
        @(negedge clk);
        // second command waits on the request channel during backpressure
        cmd_target = 2'b00;
        cmd_write  = 1'b1;
        cmd_addr   = 4'd12;
        cmd_data   = 32'h0BADC0DE;
        cmd_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            dout = 32'h77770000 + 32'(i);
            check_eq("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check_eq("bp_rsp_data",  rsp_data, 32'h5A5A0001);
            check_eq("bp_rsp_err",   {31'd0, rsp_err}, 32'd0);
            check_eq("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        check_eq("bp_hs_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check_eq("bp_hs_ready",     {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        check_eq("bp_after_rdy",   {31'd0, cmd_ready}, 32'd1);
        check_eq("bp_after_valid", {31'd0, valid}, 32'd0);
        check_eq("bp_rd_cnt",      {16'd0, rd_cnt}, 32'd2);
        @(negedge clk);
        cmd_valid = 1'b0;
        check_eq("bp2_valid", {31'd0, valid}, 32'd1);
        check_eq("bp2_din",   din, 32'h0BADC0DE);
        check_eq("bp2_addr",  {28'd0, addr}, 32'd12);
        @(negedge clk);
        check_eq("bp2_rsp",   {31'd0, rsp_valid}, 32'd1);
        @(negedge clk);
        check_eq("bp2_wr_cnt", {16'd0, wr_cnt}, 32'd2);

        // ---- reset during WAIT_RD drops the read ----
        send_cmd(2'b10, 1'b0, 4'd0, 32'h0);
        check_eq("rr_valid", {31'd0, valid}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        dout  = 32'h13572468;
        @(negedge clk);
        check_eq("rr_in_rst_rsp",  {31'd0, rsp_valid}, 32'd0);
        check_eq("rr_in_rst_rdy",  {31'd0, cmd_ready}, 32'd0);
        reset = 1'b0;
        dout  = C_JUNK;
        @(negedge clk);
        check_eq("rr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rr_valid_off", {31'd0, valid}, 32'd0);
        check_eq("rr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("rr_cnts",      {wr_cnt, rd_cnt | err_cnt}, 32'd0);
        check_eq("rr_rsp_data",  rsp_data, 32'd0);
        @(negedge clk);
        check_eq("rr_still_quiet", {30'd0, rsp_valid, valid}, 32'd0);

        send_cmd(2'b00, 1'b1, 4'd1, 32'hFEEDFACE);
        check_eq("rw_valid",   {31'd0, valid}, 32'd1);
        check_eq("rw_t1_rsp",  {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        check_eq("rw_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check_eq("rw_rsp_err",   {31'd0, rsp_err}, 32'd0);
        @(negedge clk);
        check_eq("rw_wr_cnt",    {16'd0, wr_cnt}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
